// File: rtl/seg_scan_capture.sv
// seg_scan_capture: rebuilds an 8-digit frame from a multiplexed, active-low 7-segment scan bus.
// Latency: 1 input register + STABLE_CYC stable samples per digit; frame outputs load 1 cycle after the completing accept.
// Backpressure: none, passive monitor that is always ready. Macro SEG_CAP_BIN_EN adds an 8-cycle decimal-to-binary converter.
module seg_scan_capture #(
   parameter int STABLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 500_000
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [7:0]  seg_sel,
   input  logic [7:0]  seg_led,
   output logic [31:0] digits,
   output logic [7:0]  dp,
   output logic [7:0]  blank,
   output logic [7:0]  minus,
   output logic [7:0]  bad,
   output logic        frame_valid,
   output logic        disp_off,
   output logic [26:0] bin_value,
   output logic        bin_valid,
   output logic        bin_err
);
   localparam int          TW      = $clog2(TIMEOUT_CYC + 1);
   localparam logic [7:0]  STB     = 8'(STABLE_CYC);
   localparam logic [7:0]  STB_M1  = 8'(STABLE_CYC - 1);
   localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

   logic [7:0]    r_sel, r_led, r_psel, r_pled;
   logic [7:0]    r_cnt;
   logic [7:0]    r_mask;
   logic [31:0]   r_sh_code;
   logic [7:0]    r_sh_dp, r_sh_blank, r_sh_minus, r_sh_bad;
   logic          r_load;
   logic [TW-1:0] r_to_cnt;

   logic [7:0]    w_onehot;
   logic          w_legal, w_same, w_accept;
   logic [2:0]    w_idx;
   logic [3:0]    w_code;
   logic          w_blank, w_minus, w_bad;

   // Register the raw bus once and keep the previous sample for the stability compare.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_sel  <= 8'hff;
         r_led  <= 8'hff;
         r_psel <= 8'hff;
         r_pled <= 8'hff;
      end else begin
         r_sel  <= seg_sel;
         r_led  <= seg_led;
         r_psel <= r_sel;
         r_pled <= r_led;
      end
   end

   // Legality, stability match, accept strobe and selected digit index.
   always_comb begin
      w_onehot = ~r_sel;
      w_legal  = (w_onehot != 8'd0) && ((w_onehot & (w_onehot - 8'd1)) == 8'd0);
      w_same   = ({r_sel, r_led} == {r_psel, r_pled});
      w_accept = w_legal && w_same && (r_cnt == STB_M1);
      w_idx    = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (w_onehot[i]) w_idx = 3'(i);
      end
   end

   // Glyph decode; dp is ignored so a lit decimal point does not change the digit.
   always_comb begin
      w_code  = 4'd0;
      w_blank = 1'b0;
      w_minus = 1'b0;
      w_bad   = 1'b0;
      case ({1'b1, r_led[6:0]})
         8'hc0: w_code = 4'h0;
         8'hf9: w_code = 4'h1;
         8'ha4: w_code = 4'h2;
         8'hb0: w_code = 4'h3;
         8'h99: w_code = 4'h4;
         8'h92: w_code = 4'h5;
         8'h82: w_code = 4'h6;
         8'hf8: w_code = 4'h7;
         8'h80: w_code = 4'h8;
         8'h90: w_code = 4'h9;
         8'h88: w_code = 4'ha;
         8'h83: w_code = 4'hb;
         8'hc6: w_code = 4'hc;
         8'ha1: w_code = 4'hd;
         8'h86: w_code = 4'he;
         8'h8e: w_code = 4'hf;
         8'hff: w_blank = 1'b1;
         8'hbf: w_minus = 1'b1;
         default: w_bad = 1'b1;
      endcase
   end

   // Stability counter: saturates at STABLE_CYC so one stable run accepts only once.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_cnt <= 8'd0;
      end else if (!w_legal) begin
         r_cnt <= 8'd0;
      end else if (!w_same) begin
         r_cnt <= 8'd1;
      end else if (r_cnt < STB) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   // Shadow capture, mask tracking and display-off timeout; an accept always beats the timeout.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_mask     <= 8'd0;
         r_sh_code  <= 32'd0;
         r_sh_dp    <= 8'd0;
         r_sh_blank <= 8'd0;
         r_sh_minus <= 8'd0;
         r_sh_bad   <= 8'd0;
         r_load     <= 1'b0;
         r_to_cnt   <= '0;
         disp_off   <= 1'b1;
      end else begin
         r_load <= 1'b0;
         if (w_accept) begin
            r_sh_code[{w_idx, 2'b00} +: 4] <= w_code;
            r_sh_dp[w_idx]    <= ~r_led[7];
            r_sh_blank[w_idx] <= w_blank;
            r_sh_minus[w_idx] <= w_minus;
            r_sh_bad[w_idx]   <= w_bad;
            r_to_cnt          <= '0;
            disp_off          <= 1'b0;
            if ((r_mask | w_onehot) == 8'hff) begin
               r_mask <= 8'd0;
               r_load <= 1'b1;
            end else begin
               r_mask <= r_mask | w_onehot;
            end
         end else if (r_to_cnt != TO_MAX) begin
            r_to_cnt <= r_to_cnt + TW'(1);
            if (r_to_cnt == TO_LAST) begin
               disp_off <= 1'b1;
               r_mask   <= 8'd0;
            end
         end
      end
   end

   // Frame outputs copy the shadow once per completed frame and hold otherwise.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         digits      <= 32'd0;
         dp          <= 8'd0;
         blank       <= 8'd0;
         minus       <= 8'd0;
         bad         <= 8'd0;
         frame_valid <= 1'b0;
      end else begin
         frame_valid <= r_load;
         if (r_load) begin
            digits <= r_sh_code;
            dp     <= r_sh_dp;
            blank  <= r_sh_blank;
            minus  <= r_sh_minus;
            bad    <= r_sh_bad;
         end
      end
   end

`ifdef SEG_CAP_BIN_EN
   logic [2:0]  r_bidx;
   logic        r_busy, r_lead, r_berr;
   logic [26:0] r_acc;
   logic [3:0]  w_bcode;
   logic        w_lead_nxt, w_err_nxt;
   logic [26:0] w_acc_nxt;

   // One Horner step on the digit currently pointed at, most significant first.
   always_comb begin
      w_bcode    = digits[{r_bidx, 2'b00} +: 4];
      w_lead_nxt = r_lead && blank[r_bidx];
      w_err_nxt  = r_berr | bad[r_bidx] | minus[r_bidx] |
                   (blank[r_bidx] & ~r_lead) | (w_bcode > 4'd9);
      w_acc_nxt  = (r_acc * 27'd10) + {23'd0, w_bcode};
   end

   // Conversion sequencer; a fresh frame restarts it from digit 7.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_busy    <= 1'b0;
         r_bidx    <= 3'd7;
         r_lead    <= 1'b1;
         r_berr    <= 1'b0;
         r_acc     <= 27'd0;
         bin_value <= 27'd0;
         bin_valid <= 1'b0;
         bin_err   <= 1'b0;
      end else begin
         bin_valid <= 1'b0;
         if (r_load) begin
            r_busy <= 1'b1;
            r_bidx <= 3'd7;
            r_lead <= 1'b1;
            r_berr <= 1'b0;
            r_acc  <= 27'd0;
         end else if (r_busy) begin
            r_acc  <= w_acc_nxt;
            r_lead <= w_lead_nxt;
            r_berr <= w_err_nxt;
            r_bidx <= r_bidx - 3'd1;
            if (r_bidx == 3'd0) begin
               r_busy    <= 1'b0;
               bin_valid <= 1'b1;
               bin_value <= w_acc_nxt;
               bin_err   <= w_err_nxt;
            end
         end
      end
   end
`else
   assign bin_value = 27'd0;
   assign bin_valid = 1'b0;
   assign bin_err   = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: drives scripted and random scan sequences and scores frames against a digit-level model.
// Latency: frames are checked a few cycles after the last digit of a frame is driven.
// Backpressure: none; the bench only drives the scan bus.
module tb_seg_scan_capture;
   localparam int STB  = 16;
   localparam int TOUT = 3000;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic [7:0]  seg_sel = 8'hff;
   logic [7:0]  seg_led = 8'hff;
   logic [31:0] digits;
   logic [7:0]  dp, blank, minus, bad;
   logic        frame_valid, disp_off;
   logic [26:0] bin_value;
   logic        bin_valid, bin_err;

   seg_scan_capture #(.STABLE_CYC(STB), .TIMEOUT_CYC(TOUT)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .seg_sel(seg_sel), .seg_led(seg_led),
      .digits(digits), .dp(dp), .blank(blank), .minus(minus), .bad(bad),
      .frame_valid(frame_valid), .disp_off(disp_off),
      .bin_value(bin_value), .bin_valid(bin_valid), .bin_err(bin_err)
   );

   always #5 sys_clk = ~sys_clk;

   int n_chk = 0;
   int n_err = 0;
   int fv_cnt = 0;
   int bv_cnt = 0;
   int exp_frames = 0;
   int exp_bins = 0;

   logic [7:0] glyph [16] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'h8e};

   // Model: per-digit latest capture, mask, and the expected held frame.
   logic [3:0] m_code [8];
   logic [7:0] m_dp = 0, m_blank = 0, m_minus = 0, m_bad = 0, m_mask = 0;
   logic [3:0] e_code [8];
   logic [7:0] e_dp = 0, e_blank = 0, e_minus = 0, e_bad = 0;
   logic       exp_doff = 1'b1;

   always @(negedge sys_clk) begin
      if (frame_valid === 1'b1) fv_cnt++;
      if (bin_valid === 1'b1) bv_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   function automatic logic [31:0] pack_exp();
      logic [31:0] v = 32'd0;
      for (int i = 0; i < 8; i++) v[4*i +: 4] = e_code[i];
      return v;
   endfunction

   task automatic model_clear_frame();
      for (int i = 0; i < 8; i++) e_code[i] = 4'd0;
      e_dp = 0; e_blank = 0; e_minus = 0; e_bad = 0;
   endtask

   task automatic model_accept(input int d, input logic [7:0] led);
      logic found = 1'b0;
      m_code[d] = 4'd0; m_blank[d] = 1'b0; m_minus[d] = 1'b0; m_bad[d] = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if ({1'b1, led[6:0]} == glyph[i]) begin
            m_code[d] = 4'(i);
            found = 1'b1;
         end
      end
      if (!found) begin
         if (led[6:0] == 7'h7f)      m_blank[d] = 1'b1;
         else if (led[6:0] == 7'h3f) m_minus[d] = 1'b1;
         else                        m_bad[d] = 1'b1;
      end
      m_dp[d]   = ~led[7];
      m_mask[d] = 1'b1;
      exp_doff  = 1'b0;
      if (m_mask == 8'hff) begin
         for (int i = 0; i < 8; i++) e_code[i] = m_code[i];
         e_dp = m_dp; e_blank = m_blank; e_minus = m_minus; e_bad = m_bad;
         exp_frames++;
         exp_bins++;
         m_mask = 8'd0;
      end
   endtask

   // Show one digit for `hold` cycles, then `gap` cycles of no select.
   task automatic disp(input int d, input logic [7:0] led, input int hold, input int gap);
      logic [7:0] s = 8'h01 << d;
      seg_sel = ~s;
      seg_led = led;
      cyc(hold);
      if (hold >= STB) model_accept(d, led);
      if (gap > 0) begin
         seg_sel = 8'hff;
         seg_led = 8'hff;
         cyc(gap);
      end
   endtask

   task automatic scan(input logic [63:0] f, input int lo, input int hi);
      for (int d = lo; d <= hi; d++) disp(d, f[8*d +: 8], 20, 2);
   endtask

   // Decimal value by place weights, leading blanks skipped; errors per the digit rules.
   task automatic bin_model(output logic [26:0] v, output logic e);
      longint acc = 0;
      longint w = 1;
      int top = 7;
      e = 1'b0;
      while (top >= 0 && e_blank[top]) top--;
      for (int i = 0; i <= top; i++) begin
         if (e_bad[i] || e_minus[i] || e_blank[i] || e_code[i] > 4'd9) e = 1'b1;
         acc = acc + longint'(e_code[i]) * w;
         w = w * 10;
      end
      v = acc[26:0];
   endtask

   task automatic check_frame(input string tag);
      logic [26:0] bv;
      logic        be;
      cyc(4);
      chk({tag, ".frames"}, fv_cnt, exp_frames);
      chk({tag, ".digits"}, digits, pack_exp());
      chk({tag, ".dp"}, dp, e_dp);
      chk({tag, ".blank"}, blank, e_blank);
      chk({tag, ".minus"}, minus, e_minus);
      chk({tag, ".bad"}, bad, e_bad);
      chk({tag, ".disp_off"}, disp_off, exp_doff);
`ifdef SEG_CAP_BIN_EN
      for (int t = 0; t < 20 && bv_cnt != exp_bins; t++) cyc(1);
      chk({tag, ".bin_cnt"}, bv_cnt, exp_bins);
      bin_model(bv, be);
      chk({tag, ".bin_err"}, bin_err, be);
      if (!be) chk({tag, ".bin_value"}, bin_value, bv);
`else
      bin_model(bv, be);
      chk({tag, ".bin_value"}, bin_value, 27'd0);
      chk({tag, ".bin_err"}, {bin_err, bin_valid}, 2'b00);
`endif
   endtask

   function automatic logic [7:0] rand_led();
      logic [7:0] l;
      int r = $urandom_range(9, 0);
      if (r < 7)       l = glyph[$urandom_range(15, 0)];
      else if (r == 7) l = 8'hff;
      else if (r == 8) l = 8'hbf;
      else             l = 8'($urandom);
      l[7] = ($urandom_range(3, 0) != 0);
      return l;
   endfunction

   initial begin
      int frames_before;
      int order [8];
      int tmp;
      logic [7:0] led, gl;
      for (int i = 0; i < 8; i++) begin
         m_code[i] = 4'd0;
         e_code[i] = 4'd0;
      end

      // Reset state
      cyc(3);
      chk("rst.digits", digits, 32'd0);
      chk("rst.flags", {dp, blank, minus, bad}, 32'd0);
      chk("rst.frame_valid", frame_valid, 1'b0);
      chk("rst.disp_off", disp_off, 1'b1);
      chk("rst.bin", {bin_valid, bin_err, bin_value}, 29'd0);
      sys_rst = 1'b0;
      cyc(2);

      // Directed frame "01003000"
      scan(64'hc0f9c0c0_b0c0c0c0, 0, 7);
      check_frame("f01003000");
      chk("f01003000.value", digits, 32'h01003000);

      // Ghost 8 on digit 2 before the real 3
      for (int d = 0; d < 8; d++) begin
         if (d == 2) begin
            disp(2, 8'h80, 5, 0);
            disp(2, 8'hb0, 20, 2);
         end else begin
            disp(d, glyph[d + 1], 20, 2);
         end
      end
      check_frame("ghost");
      chk("ghost.digit2", digits[11:8], 4'd3);

      // Blank, minus and decimal point
      scan(64'hffbff9a4_b0999240, 0, 7);
      check_frame("blankminus");
      chk("blankminus.blank", blank, 8'h80);
      chk("blankminus.minus", minus, 8'h40);
      chk("blankminus.dp0", dp[0], 1'b1);
      chk("blankminus.d0", digits[3:0], 4'd0);

      // Illegal selects do not disturb a partial frame
      frames_before = fv_cnt;
      scan(64'hc0f9a4b0_99928280, 0, 3);
      for (int i = 0; i < 1000; i++) begin
         seg_sel = i[0] ? 8'hfc : 8'hff;
         seg_led = 8'($urandom);
         cyc(1);
      end
      chk("illegal.frames", fv_cnt, frames_before);
      chk("illegal.disp_off", disp_off, 1'b0);
      scan(64'hc0f9a4b0_99928280, 4, 7);
      check_frame("illegal_resume");

      // Timeout clears the mask and raises disp_off
      scan(64'h90f8a4b0_99928280, 0, 3);
      seg_sel = 8'hfc;
      cyc(TOUT + 500);
      m_mask = 8'd0;
      exp_doff = 1'b1;
      chk("timeout.disp_off", disp_off, 1'b1);
      frames_before = fv_cnt;
      scan(64'h90f8a4b0_99928280, 4, 7);
      cyc(4);
      chk("timeout.no_frame", fv_cnt, frames_before);
      chk("timeout.disp_on", disp_off, 1'b0);
      scan(64'h90f8a4b0_99928280, 0, 7);
      check_frame("timeout_full");

      // Mid-frame reset discards the partial frame
      scan(64'hc0c0c0c0_f9f9f9f9, 0, 4);
      sys_rst = 1'b1;
      cyc(1);
      sys_rst = 1'b0;
      m_mask = 8'd0;
      model_clear_frame();
      exp_doff = 1'b1;
      cyc(1);
      chk("midrst.digits", digits, 32'd0);
      chk("midrst.disp_off", disp_off, 1'b1);
      frames_before = fv_cnt;
      scan(64'hc0c0c0c0_f9f9f9f9, 5, 7);
      cyc(4);
      chk("midrst.no_frame", fv_cnt, frames_before);
      scan(64'hc0c0c0c0_f9f9f9f9, 0, 7);
      check_frame("midrst_full");

`ifdef SEG_CAP_BIN_EN
      // Reset during a conversion suppresses its result
      scan(64'hf9a4b0_99928280f8 & 64'hffffffff_ffffffff, 0, 7);
      for (int t = 0; t < 20 && fv_cnt != exp_frames; t++) cyc(1);
      cyc(2);
      sys_rst = 1'b1;
      cyc(1);
      sys_rst = 1'b0;
      exp_bins--;
      m_mask = 8'd0;
      model_clear_frame();
      exp_doff = 1'b1;
      cyc(12);
      chk("convrst.bin_cnt", bv_cnt, exp_bins);
      chk("convrst.bin_value", bin_value, 27'd0);
`endif

      // Random frames with ghosts, random order and recaptures
      for (int f = 0; f < 12; f++) begin
         for (int i = 0; i < 8; i++) order[i] = i;
         for (int i = 7; i > 0; i--) begin
            int j = $urandom_range(i, 0);
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
         end
         for (int k = 0; k < 8; k++) begin
            led = rand_led();
            if ($urandom_range(2, 0) == 0) begin
               gl = rand_led();
               if (gl == led) gl = led ^ 8'h01;
               disp(order[k], gl, $urandom_range(STB - 1, 1), $urandom_range(2, 0));
            end
            disp(order[k], led, $urandom_range(STB + 8, STB), $urandom_range(3, 1));
            if (k < 7 && $urandom_range(3, 0) == 0)
               disp(order[$urandom_range(k, 0)], rand_led(), $urandom_range(STB + 8, STB), 2);
         end
         check_frame("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
